uart_rx_packet_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_pkt_buf.sv | 31 +++
 rtl/uart_rx_packet_ctrl.sv | 152 +++++++++++++++
 tb/tb_uart_rx_packet_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, default SOF marker and error indices for the UART frame controller
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    localparam int ERR_CHK     = 0;
    localparam int ERR_LEN     = 1;
    localparam int ERR_OVERRUN = 2;
    localparam int ERR_TIMEOUT = 3;
    localparam int ERR_W       = 4;

endpackage

// File: rtl/uart_pkt_buf.sv
// rtl/uart_pkt_buf.sv - payload buffer, one write port and one registered read port
module uart_pkt_buf #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [2**AW];

    // Storage is left unreset; only the read register comes up clean.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 8'd0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_rx_packet_ctrl.sv
// rtl/uart_rx_packet_ctrl.sv - SOF/LEN/PAYLOAD/CHK frame parser with host handshake; UART_PKT_TIMEOUT_EN enables the inter-byte timeout
module uart_rx_packet_ctrl
    import uart_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE     = SOF_DEFAULT,
    parameter int         MAX_LEN      = 16,
    parameter int         BUF_AW       = 4,
    parameter int         TIMEOUT_CLKS = 100_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic [BUF_AW-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              pkt_ready,
    output logic [7:0]        pkt_len,
    input  logic              pkt_ack,
    output logic              err_chk,
    output logic              err_len,
    output logic              err_overrun,
    output logic              err_timeout
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t           state;
    logic [7:0]       len;
    logic [7:0]       idx;
    logic [7:0]       chk;
    logic [ERR_W-1:0] err_q;
    logic             wr_en;
    logic             tmo_expire;

    assign wr_en = rx_done && (state == ST_PAYLOAD);

`ifdef UART_PKT_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    logic [TW-1:0] tmo_cnt;
    logic          in_frame;

    assign in_frame   = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK);
    // A byte landing on the expiry cycle takes priority over the timeout.
    assign tmo_expire = in_frame && (tmo_cnt == TMO_LAST) && !rx_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (!in_frame || rx_done || tmo_expire) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    assign tmo_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            len       <= 8'd0;
            idx       <= 8'd0;
            chk       <= 8'd0;
            err_q     <= '0;
            pkt_ready <= 1'b0;
            pkt_len   <= 8'd0;
        end else begin
            err_q <= '0;
            if (tmo_expire) begin
                state              <= ST_IDLE;
                err_q[ERR_TIMEOUT] <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rx_done && (rx_data == SOF_BYTE)) begin
                            state <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (rx_done) begin
                            len <= rx_data;
                            chk <= rx_data;
                            idx <= 8'd0;
                            if (rx_data > MAX_LEN_B) begin
                                state          <= ST_IDLE;
                                err_q[ERR_LEN] <= 1'b1;
                            end else if (rx_data == 8'd0) begin
                                state <= ST_CHK;
                            end else begin
                                state <= ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (rx_done) begin
                            chk <= chk ^ rx_data;
                            idx <= idx + 8'd1;
                            if (idx == len - 8'd1) begin
                                state <= ST_CHK;
                            end
                        end
                    end
                    ST_CHK: begin
                        if (rx_done) begin
                            if (rx_data == chk) begin
                                state     <= ST_HOLD;
                                pkt_ready <= 1'b1;
                                pkt_len   <= len;
                            end else begin
                                state          <= ST_IDLE;
                                err_q[ERR_CHK] <= 1'b1;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (rx_done) begin
                            err_q[ERR_OVERRUN] <= 1'b1;
                        end
                        if (pkt_ack) begin
                            state     <= ST_IDLE;
                            pkt_ready <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign err_chk     = err_q[ERR_CHK];
    assign err_len     = err_q[ERR_LEN];
    assign err_overrun = err_q[ERR_OVERRUN];
    assign err_timeout = err_q[ERR_TIMEOUT];

    uart_pkt_buf #(
        .AW (BUF_AW)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (idx[BUF_AW-1:0]),
        .wr_data (rx_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// tb/tb_uart_rx_packet_ctrl.sv - scoreboard bench for uart_rx_packet_ctrl, directed frames plus random frame mix
module tb_uart_rx_packet_ctrl;

    localparam int MAXL = 16;
    localparam int AW   = 4;
    localparam int TCLK = 20;

    localparam int K_PKT = 0;
    localparam int K_CHK = 1;
    localparam int K_LEN = 2;
    localparam int K_OVR = 3;
    localparam int K_TMO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_done = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    rd_data;
    logic          pkt_ready;
    logic [7:0]    pkt_len;
    logic          pkt_ack = 1'b0;
    logic          err_chk, err_len, err_overrun, err_timeout;

    uart_rx_packet_ctrl #(
        .SOF_BYTE     (8'hA5),
        .MAX_LEN      (MAXL),
        .BUF_AW       (AW),
        .TIMEOUT_CLKS (TCLK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .pkt_ready   (pkt_ready),
        .pkt_len     (pkt_len),
        .pkt_ack     (pkt_ack),
        .err_chk     (err_chk),
        .err_len     (err_len),
        .err_overrun (err_overrun),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int exp_kind [$];
    int exp_len  [$];
    logic [7:0] pl   [256];
    int         pl_len;
    logic [7:0] held [256];
    int         held_len = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic expect_event(input int kind, input int len);
        exp_kind.push_back(kind);
        exp_len.push_back(len);
    endtask

    task automatic pop_check(input int kind, input int len);
        int ek, el;
        if (exp_kind.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_event: got kind %0d, expected no event", kind);
        end else begin
            ek = exp_kind.pop_front();
            el = exp_len.pop_front();
            check("event_kind", kind, ek);
            if (kind == K_PKT && ek == K_PKT) check("pkt_len", len, el);
        end
    endtask

    // Monitor: every error pulse or pkt_ready rising edge consumes one expected event.
    initial begin
        logic       prev_ready;
        logic [3:0] errs;
        int         kind;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ready = 1'b0;
            end else begin
                errs = {err_timeout, err_overrun, err_len, err_chk};
                if (errs != 4'd0) begin
                    check("err_onehot", $countones(errs), 1);
                    kind = errs[0] ? K_CHK : errs[1] ? K_LEN : errs[2] ? K_OVR : K_TMO;
                    pop_check(kind, 0);
                end
                if (pkt_ready && !prev_ready) pop_check(K_PKT, int'(pkt_len));
                prev_ready = pkt_ready;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge clk);
        #1;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    // Reference: checksum is LEN xor all payload bytes; LEN above MAXL aborts right after LEN.
    task automatic tx_frame(input int kind, input logic [7:0] chk_flip, input int gap_max);
        logic [7:0] chk;
        chk = pl_len[7:0];
        for (int i = 0; i < pl_len; i++) chk ^= pl[i];
        if (kind == K_PKT) begin
            expect_event(K_PKT, pl_len);
            held_len = pl_len;
            for (int i = 0; i < pl_len; i++) held[i] = pl[i];
        end else begin
            expect_event(kind, 0);
        end
        send_byte(8'hA5, $urandom_range(0, gap_max));
        send_byte(pl_len[7:0], $urandom_range(0, gap_max));
        if (kind != K_LEN) begin
            for (int i = 0; i < pl_len; i++) send_byte(pl[i], $urandom_range(0, gap_max));
            send_byte(chk ^ chk_flip, $urandom_range(0, gap_max));
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!pkt_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("pkt_ready_wait", int'(pkt_ready), 1);
    endtask

    task automatic read_check();
        for (int i = 0; i < held_len; i++) begin
            rd_addr = AW'(i);
            @(posedge clk);
            #1;
            check("rd_data", int'(rd_data), int'(held[i]));
        end
    endtask

    task automatic ack(input bit with_byte);
        pkt_ack = 1'b1;
        if (with_byte) begin
            expect_event(K_OVR, 0);
            rx_data = 8'($urandom_range(0, 255));
            rx_done = 1'b1;
        end
        @(posedge clk);
        #1;
        pkt_ack = 1'b0;
        rx_done = 1'b0;
        check("pkt_ready_after_ack", int'(pkt_ready), 0);
    endtask

    task automatic load3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        pl[0] = a;
        pl[1] = b;
        pl[2] = c;
        pl_len = 3;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [7:0] g;

        #22;
        check("reset_pkt_ready", int'(pkt_ready), 0);
        check("reset_pkt_len", int'(pkt_len), 0);
        check("reset_rd_data", int'(rd_data), 0);
        check("reset_err", int'({err_timeout, err_overrun, err_len, err_chk}), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1 and T4
        load3(8'h11, 8'h22, 8'h33);
        tx_frame(K_PKT, 8'h00, 0);
        wait_ready();
        read_check();
        expect_event(K_OVR, 0);
        send_byte(8'h77, 0);
        read_check();
        check("hold_after_overrun", int'(pkt_ready), 1);
        ack(1'b1);

        // T2: A5 02 AA BB 00, then a good frame
        pl[0] = 8'hAA;
        pl[1] = 8'hBB;
        pl_len = 2;
        tx_frame(K_CHK, 8'h13, 0);
        repeat (3) @(posedge clk);
        #1;
        check("no_ready_after_bad_chk", int'(pkt_ready), 0);
        load3(8'hA5, 8'h00, 8'hFF);
        tx_frame(K_PKT, 8'h00, 1);
        wait_ready();
        read_check();
        ack(1'b0);

        // T3: LEN 0x11 rejected, stray byte, then an empty frame
        pl_len = 17;
        tx_frame(K_LEN, 8'h00, 0);
        send_byte(8'h55, 0);
        pl_len = 0;
        tx_frame(K_PKT, 8'h00, 0);
        wait_ready();
        ack(1'b0);

        // Full-length frame at the buffer depth limit
        pl_len = MAXL;
        for (int i = 0; i < MAXL; i++) pl[i] = 8'($urandom_range(0, 255));
        tx_frame(K_PKT, 8'h00, 0);
        wait_ready();
        read_check();
        ack(1'b0);

`ifdef UART_PKT_TIMEOUT_EN
        // T5: expiry, then a byte exactly on the expiry cycle
        expect_event(K_TMO, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        repeat (TCLK + 3) @(posedge clk);
        #1;
        load3(8'h11, 8'h22, 8'h00);
        pl_len = 2;
        expect_event(K_PKT, 2);
        held_len = 2;
        held[0] = 8'h11;
        held[1] = 8'h22;
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, TCLK - 1);
        send_byte(8'h02 ^ 8'h11 ^ 8'h22, TCLK - 1);
        wait_ready();
        read_check();
        ack(1'b0);
`else
        // Without the timeout a partial frame waits indefinitely
        expect_event(K_PKT, 2);
        held_len = 2;
        held[0] = 8'h11;
        held[1] = 8'h22;
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 150);
        send_byte(8'h02 ^ 8'h11 ^ 8'h22, 0);
        wait_ready();
        read_check();
        ack(1'b0);
`endif

        // T6: reset mid-payload
        rd_addr = '0;
        send_byte(8'hA5, 0);
        send_byte(8'h05, 0);
        send_byte(8'h5A, 0);
        send_byte(8'h5A, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_pkt_ready", int'(pkt_ready), 0);
        check("midreset_pkt_len", int'(pkt_len), 0);
        check("midreset_rd_data", int'(rd_data), 0);
        check("midreset_err", int'({err_timeout, err_overrun, err_len, err_chk}), 0);
        #13;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load3(8'h01, 8'h02, 8'h03);
        tx_frame(K_PKT, 8'h00, 0);
        wait_ready();
        read_check();
        ack(1'b0);

        // Random frame mix
        for (int f = 0; f < 40; f++) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h5A;
                send_byte(g, $urandom_range(0, 2));
            end
            r = $urandom_range(0, 99);
            if (r < 80) begin
                pl_len = $urandom_range(0, MAXL);
                for (int i = 0; i < pl_len; i++) pl[i] = 8'($urandom_range(0, 255));
                if (r < 60) begin
                    tx_frame(K_PKT, 8'h00, 2);
                    wait_ready();
                    read_check();
                    if ($urandom_range(0, 3) == 0) begin
                        expect_event(K_OVR, 0);
                        send_byte(8'($urandom_range(0, 255)), 0);
                        read_check();
                    end
                    ack($urandom_range(0, 1) == 1);
                end else begin
                    tx_frame(K_CHK, 8'($urandom_range(1, 255)), 2);
                end
            end else begin
                pl_len = $urandom_range(MAXL + 1, 255);
                tx_frame(K_LEN, 8'h00, 2);
            end
        end

        repeat (5) @(posedge clk);
        #1;
        check("exp_queue_empty", exp_kind.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
